// File: rtl/fco_sweep_if.sv
// Control bundle between a sweep requester and the fco_sweep sequencer.
// The master side programs and starts sweeps; the slave side drives the cutoff.
interface fco_sweep_if #(
  parameter int BITWIDTH = 32,
  parameter int DWELL_W  = 16
);
  logic                start;
  logic                abort;
  logic [BITWIDTH-1:0] fco_start;
  logic [BITWIDTH-1:0] fco_stop;
  logic [BITWIDTH-1:0] fco_step;
  logic [DWELL_W-1:0]  dwell;
  logic [BITWIDTH-1:0] fco;
  logic                busy;
  logic                step_strobe;
  logic                done;

  modport master (
    output start, abort, fco_start, fco_stop, fco_step, dwell,
    input  fco, busy, step_strobe, done
  );

  modport slave (
    input  start, abort, fco_start, fco_stop, fco_step, dwell,
    output fco, busy, step_strobe, done
  );
endinterface

// File: rtl/fco_sweep.sv
// Cutoff-frequency sequencer: steps fco from a start to a stop value in fixed
// increments, holding each value for a programmed number of cycles.
module fco_sweep #(
  parameter int BITWIDTH = 32,
  parameter int DWELL_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  fco_sweep_if.slave  bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_reg;
  logic [BITWIDTH-1:0] fco_reg;
  logic [BITWIDTH-1:0] stop_reg;
  logic [BITWIDTH-1:0] step_reg;
  logic [DWELL_W-1:0]  dwell_m1_reg;
  logic [DWELL_W-1:0]  cnt_reg;
  logic                up_reg;
  logic                busy_reg;
  logic                strobe_reg;
  logic                done_reg;

  logic [BITWIDTH:0]   sum_ext;
  logic [BITWIDTH:0]   diff_ext;
  logic [BITWIDTH-1:0] fco_next;
  logic [DWELL_W-1:0]  dwell_m1;

  // A dwell of zero behaves like a dwell of one.
  assign dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  // The extra top bit flags wrap-around (up) or underflow (down); either case,
  // a zero step, or passing stop all clamp the next value to stop.
  always_comb begin
    sum_ext  = {1'b0, fco_reg} + {1'b0, step_reg};
    diff_ext = {1'b0, fco_reg} - {1'b0, step_reg};
    fco_next = stop_reg;
    if (step_reg != '0) begin
      if (up_reg) begin
        if (!sum_ext[BITWIDTH] && (sum_ext[BITWIDTH-1:0] < stop_reg))
          fco_next = sum_ext[BITWIDTH-1:0];
      end else begin
        if (!diff_ext[BITWIDTH] && (diff_ext[BITWIDTH-1:0] > stop_reg))
          fco_next = diff_ext[BITWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      fco_reg      <= '0;
      stop_reg     <= '0;
      step_reg     <= '0;
      dwell_m1_reg <= '0;
      cnt_reg      <= '0;
      up_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      strobe_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            stop_reg     <= bus.fco_stop;
            step_reg     <= bus.fco_step;
            dwell_m1_reg <= dwell_m1;
            up_reg       <= (bus.fco_stop >= bus.fco_start);
            fco_reg      <= bus.fco_start;
            cnt_reg      <= dwell_m1;
            strobe_reg   <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= SWEEP;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - DWELL_W'(1);
          end else if (fco_reg == stop_reg) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            fco_reg    <= fco_next;
            cnt_reg    <= dwell_m1_reg;
            strobe_reg <= 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.fco         = fco_reg;
  assign bus.busy        = busy_reg;
  assign bus.step_strobe = strobe_reg;
  assign bus.done        = done_reg;

endmodule

// File: tb/tb_fco_sweep.sv
// Directed bench for fco_sweep: up/down/wrap sweeps, degenerate inputs,
// abort cases and asynchronous reset, checked cycle by cycle.
module tb_fco_sweep;

  localparam int BW = 32;
  localparam int DW = 16;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   down_vals [6];

  fco_sweep_if #(.BITWIDTH(BW), .DWELL_W(DW)) bus ();

  fco_sweep #(.BITWIDTH(BW), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW+2:0] pack(input logic [BW-1:0] f, input logic b,
                                         input logic s, input logic d);
    return {f, b, s, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW+2:0] exp);
    logic [BW+2:0] obs;
    obs = {bus.fco, bus.busy, bus.step_strobe, bus.done};
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed fco=%h busy=%b strobe=%b done=%b expected fco=%h busy=%b strobe=%b done=%b",
             tag, obs[BW+2:3], obs[2], obs[1], obs[0], exp[BW+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic cfg(input logic [BW-1:0] s, input logic [BW-1:0] e,
                     input logic [BW-1:0] st, input logic [DW-1:0] dw);
    bus.fco_start = s;
    bus.fco_stop  = e;
    bus.fco_step  = st;
    bus.dwell     = dw;
  endtask

  // Sample start on the next edge (N); returns in cycle N+1.
  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // 100..130 step 10 dwell 3; optionally pulse start with junk config mid-sweep.
  task automatic up_sweep(input string tag, input bit poke);
    cfg(100, 130, 10, 3);
    go();
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12)
        chk(tag, pack(BW'(100 + 10 * ((c - 1) / 3)), 1'b1, ((c - 1) % 3) == 0, 1'b0));
      else
        chk(tag, pack(130, 1'b0, 1'b0, 1'b1));
      if (poke && c == 4) begin
        bus.start = 1'b1;
        cfg(999, 0, 1, 0);
      end
      if (poke && c == 6) bus.start = 1'b0;
      tick();
    end
    chk(tag, pack(130, 1'b0, 1'b0, 1'b0));
    $display("[TB] %s sweep 100->130 checked", tag);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    down_vals = '{50, 43, 36, 29, 22, 20};
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(0, 0, 0, 0);

    #3;
    chk("reset", pack(0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("reset_hold", pack(0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    tick();
    chk("idle", pack(0, 1'b0, 1'b0, 1'b0));

    // Up sweep with start pulses while busy that must be ignored.
    up_sweep("up_poke", 1'b1);

    // Down sweep with clamp, restart accepted in the done cycle into a wrap sweep.
    cfg(50, 20, 7, 1);
    go();
    for (int c = 1; c <= 6; c++) begin
      chk("down", pack(BW'(down_vals[c-1]), 1'b1, 1'b1, 1'b0));
      tick();
    end
    chk("down_done", pack(20, 1'b0, 1'b0, 1'b1));
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2);
    go();
    chk("wrap_c1", pack(32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0));
    tick();
    chk("wrap_c2", pack(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("wrap_c3", pack(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0));
    tick();
    chk("wrap_c4", pack(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
    tick();
    chk("wrap_done", pack(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1));
    tick();
    chk("wrap_after", pack(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    $display("[TB] down 50->20 and wrap sweeps checked");

    // dwell=0, step=0: single jump to stop, one cycle each.
    cfg(5, 9, 0, 0);
    go();
    chk("step0_c1", pack(5, 1'b1, 1'b1, 1'b0));
    tick();
    chk("step0_c2", pack(9, 1'b1, 1'b1, 1'b0));
    tick();
    chk("step0_done", pack(9, 1'b0, 1'b0, 1'b1));

    // start == stop: single value.
    cfg(7, 7, 3, 1);
    go();
    chk("same_c1", pack(7, 1'b1, 1'b1, 1'b0));
    tick();
    chk("same_done", pack(7, 1'b0, 1'b0, 1'b1));
    tick();
    $display("[TB] degenerate sweeps checked");

    // Abort sampled at N+5 during the up sweep.
    cfg(100, 130, 10, 3);
    go();
    for (int c = 1; c < 5; c++) tick();
    chk("abort_pre", pack(110, 1'b1, 1'b0, 1'b0));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", pack(110, 1'b0, 1'b0, 1'b0));
    for (int c = 0; c < 10; c++) tick();
    chk("abort_nodone", pack(110, 1'b0, 1'b0, 1'b0));

    // abort together with start in IDLE keeps IDLE.
    cfg(5, 9, 1, 1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("idle_abort_start", pack(110, 1'b0, 1'b0, 1'b0));
    tick();
    chk("idle_abort_start2", pack(110, 1'b0, 1'b0, 1'b0));
    $display("[TB] abort cases checked");

    // Abort on the final expiry cycle of the down sweep suppresses done.
    cfg(50, 20, 7, 1);
    go();
    for (int c = 1; c < 6; c++) tick();
    chk("final_pre", pack(20, 1'b1, 1'b1, 1'b0));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("final_abort", pack(20, 1'b0, 1'b0, 1'b0));
    tick();
    chk("final_hold", pack(20, 1'b0, 1'b0, 1'b0));
    $display("[TB] abort on final expiry checked");

    // Asynchronous reset mid-dwell, away from any clock edge.
    cfg(100, 130, 10, 3);
    go();
    tick();
    chk("pre_rst", pack(100, 1'b1, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", pack(0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("async_rst_hold", pack(0, 1'b0, 1'b0, 1'b0));
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", pack(0, 1'b0, 1'b0, 1'b0));
    up_sweep("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fco_sweep.md
# fco_sweep

Cutoff-frequency sequencer that drives the `fco` control input of the variable digital filter. On a start request it steps `fco` from a programmed start value to a stop value in fixed increments and holds each value for a programmed dwell time. Supported uses are characterising the filter's response across its cutoff range and scheduled retuning in-system. It is the control-side source for the filter's cutoff port and shares that port's width.

## Interface
- `BITWIDTH`, 32, width of `fco` and of all cutoff configuration values; must match the filter's `BITWIDTH`.
- `DWELL_W`, 16, width of the dwell counter and of the `dwell` input.

- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begins a sweep when sampled high in IDLE.
- `abort`  input  1  terminates the sweep; has priority over every other event.
- `fco_start`  input  BITWIDTH  first cutoff value, unsigned.
- `fco_stop`  input  BITWIDTH  final cutoff value, unsigned.
- `fco_step`  input  BITWIDTH  increment magnitude, unsigned.
- `dwell`  input  DWELL_W  number of cycles each value is held; 0 is treated as 1.
- `fco`  output  BITWIDTH  registered cutoff value driven to the filter.
- `busy`  output  1  high while the sweep is in state SWEEP.
- `step_strobe`  output  1  one-cycle pulse in the first cycle each new `fco` value is valid.
- `done`  output  1  one-cycle pulse when a sweep completes normally.

## Operation
- States:
  - IDLE: default state.
  - SWEEP: the dwell counter runs and `fco` steps.
- Reset values: `fco`=0, `busy`=0, `step_strobe`=0, `done`=0, state IDLE, dwell counter 0.
- Configuration capture:
  - In IDLE, `start`=1 with `abort`=0 latches `fco_start`, `fco_stop`, `fco_step`, and D = max(`dwell`,1).
  - Direction is latched as up if `fco_stop` >= `fco_start`, otherwise down.
  - Input changes after capture have no effect until the next start.
- Entering SWEEP: `fco` <= `fco_start`, `step_strobe`=1, counter <= D-1.
- In SWEEP, while the counter is > 0: decrement the counter; `fco` holds.
- In SWEEP, when the counter = 0:
  - If `fco` = stop: go to IDLE and pulse `done`.
  - Otherwise: `fco` <= next, `step_strobe`=1, counter <= D-1.
- Next-value arithmetic:
  - Computed at BITWIDTH+1 bits, unsigned.
  - Up: next = min(`fco`+step, stop).
  - Down: next = max(`fco`-step, stop), with an underflow check on the extra bit.
  - Any overshoot, wrap-around or underflow is clamped to stop; `fco` never leaves the closed interval [start, stop].
- `fco_step`=0 is treated as a single jump: the next value is stop.
- `start` is ignored while `busy`=1.
- Abort:
  - In SWEEP: go to IDLE next cycle, `fco` holds its current value, no `done`, no `step_strobe`.
  - In IDLE, `abort` and `start` together: stay in IDLE.
  - `abort` on the final expiry cycle: abort wins and `done` does not pulse.
- After completion or abort, `fco` holds its last value until the next sweep or reset.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronously).

## Timing
- Start sampled at edge N → `fco`=`fco_start`, `busy`=1, `step_strobe`=1 from N+1.
- Each value is held exactly D cycles. Value k (k = 0..K-1) first appears at N+1+k·D.
- K = ceil(|stop-start| / step) + 1, or 1 if start = stop. If step = 0, K = 2 when start ≠ stop.
- `done`=1 and `busy`=0 at N+1+K·D, for one cycle only.
- Earliest accepted restart: `start` sampled in the `done` cycle → new sweep begins the cycle after.
- Abort sampled at edge M while in SWEEP → `busy`=0 at M+1.

## Test plan
- Up sweep: start=100, stop=130, step=10, dwell=3, start at N → `fco` 100/110/120/130, each held 3 cycles starting at N+1, N+4, N+7, N+10; 4 `step_strobe` pulses; `done` at N+13.
- Down sweep with clamp: start=50, stop=20, step=7, dwell=1 → `fco` 50, 43, 36, 29, 22, 20 on consecutive cycles; `done` at N+7; `fco` stays 20 afterwards.
- Wrap-around clamp: start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20, dwell=2 → `fco` 0xFFFF_FFF0 then 0xFFFF_FFFF, never 0x10; `done` at N+5.
- Degenerate inputs:
  - dwell=0, step=0, start=5, stop=9 → `fco` 5 then 9, one cycle each; `done` at N+3.
  - start=stop=7 → single value 7; `done` at N+2.
- Abort and ignored start:
  - During the first up sweep, assert `abort` at N+5 → `busy`=0 at N+6, `fco` holds 110, no `done`.
  - `start` pulses while `busy`=1 are ignored.
  - `abort` coincident with the final expiry cycle → no `done`.
- Async reset: assert `rst` mid-dwell, off a clock edge → `fco`=0, `busy`=0, `step_strobe`=0 and `done`=0 immediately. After release, a new start runs a full sweep that matches the first scenario.
